// File: rtl/present_key_sched_pkg.sv
// Shared constants for the PRESENT-80 key scheduler: widths, round count, FSM encodings, S-boxes.
// The optional decrypt path is built when PRESENT_DEC_EN is defined.
package present_pkg;

    localparam int KEY_W   = 80;
    localparam int RK_W    = 64;
    localparam int CNT_W   = 5;
    localparam int IDX_W   = 6;
    localparam int NROUNDS = 32;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRECOMP = 2'd1;
    localparam logic [1:0] S_SERVE   = 2'd2;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [3:0] INV_SBOX [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

endpackage

// File: rtl/present_key_step.sv
// One PRESENT-80 key-register update (forward, or inverse when PRESENT_DEC_EN is defined).
// Purely combinational; the caller owns the key register and the round counter.
module present_key_step
    import present_pkg::*;
(
    input  logic [KEY_W-1:0] key_i,
    input  logic [CNT_W-1:0] cnt_i,
`ifdef PRESENT_DEC_EN
    input  logic             inv_i,
`endif
    output logic [KEY_W-1:0] key_o
);

    logic [KEY_W-1:0] rot_f;
    logic [KEY_W-1:0] fwd;

    // Rotate left 61, S-box the top nibble, fold the counter into bits 19:15.
    assign rot_f = {key_i[18:0], key_i[79:19]};
    assign fwd   = {SBOX[rot_f[79:76]], rot_f[75:20], rot_f[19:15] ^ cnt_i, rot_f[14:0]};

`ifdef PRESENT_DEC_EN
    logic [KEY_W-1:0] x_i;
    logic [KEY_W-1:0] s_i;
    logic [KEY_W-1:0] inv;

    // Undo the forward steps in reverse order; the final rotate right 61 equals rotate left 19.
    assign x_i = {key_i[79:20], key_i[19:15] ^ cnt_i, key_i[14:0]};
    assign s_i = {INV_SBOX[x_i[79:76]], x_i[75:0]};
    assign inv = {s_i[60:0], s_i[79:61]};

    assign key_o = inv_i ? inv : fwd;
`else
    assign key_o = fwd;
`endif

endmodule

// File: rtl/present_key_sched.sv
// Sequential PRESENT-80 key scheduler: delivers K1..K32 one per valid/ready transfer.
// Define PRESENT_DEC_EN to add inDecrypt, which precomputes K32 and then serves K32..K1.
module present_key_sched
    import present_pkg::*;
(
    input  logic              inClk,
    input  logic              inRstN,
    input  logic              inStart,
    input  logic [KEY_W-1:0]  inKey,
`ifdef PRESENT_DEC_EN
    input  logic              inDecrypt,
`endif
    output logic [RK_W-1:0]   outRoundKey,
    output logic              outValid,
    input  logic              inReady,
    output logic [IDX_W-1:0]  outRoundIdx,
    output logic              outBusy,
    output logic              outDone
);

    logic [1:0]       state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;
    logic [KEY_W-1:0] key_nxt;
    logic             last_xfer;

`ifdef PRESENT_DEC_EN
    logic dec_q, dec_d;
    logic step_inv;

    // PRECOMP always steps forward; only serving a decrypt run walks backwards.
    assign step_inv  = dec_q && (state_q == S_SERVE);
    assign last_xfer = dec_q ? (idx_q == 6'd1) : (idx_q == 6'(NROUNDS));
`else
    assign last_xfer = (idx_q == 6'(NROUNDS));
`endif

    present_key_step u_step (
        .key_i (key_q),
        .cnt_i (cnt_q),
`ifdef PRESENT_DEC_EN
        .inv_i (step_inv),
`endif
        .key_o (key_nxt)
    );

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
`ifdef PRESENT_DEC_EN
        dec_d   = dec_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (inStart) begin
                    key_d   = inKey;
                    cnt_d   = 5'd1;
                    idx_d   = 6'd1;
                    state_d = S_SERVE;
`ifdef PRESENT_DEC_EN
                    dec_d   = inDecrypt;
                    if (inDecrypt) begin
                        idx_d   = 6'(NROUNDS);
                        state_d = S_PRECOMP;
                    end
`endif
                end
            end
`ifdef PRESENT_DEC_EN
            S_PRECOMP: begin
                // Counter parks at 31 so the first inverse step undoes the last forward one.
                key_d = key_nxt;
                if (cnt_q == 5'd31) begin
                    state_d = S_SERVE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
`endif
            S_SERVE: begin
                if (inReady) begin
                    if (last_xfer) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        key_d = key_nxt;
`ifdef PRESENT_DEC_EN
                        if (dec_q) begin
                            cnt_d = cnt_q - 5'd1;
                            idx_d = idx_q - 6'd1;
                        end else begin
                            cnt_d = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
                            idx_d = idx_q + 6'd1;
                        end
`else
                        cnt_d = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
                        idx_d = idx_q + 6'd1;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge inClk) begin
        if (!inRstN) begin
            state_q <= S_IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
`ifdef PRESENT_DEC_EN
            dec_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
`ifdef PRESENT_DEC_EN
            dec_q   <= dec_d;
`endif
        end
    end

    assign outRoundKey = key_q[79:16];
    assign outValid    = (state_q == S_SERVE);
    assign outRoundIdx = idx_q;
    assign outBusy     = (state_q != S_IDLE);
    assign outDone     = done_q;

endmodule

// File: tb/tb_present_key_sched.sv
// Directed bench for present_key_sched; also exercises the decrypt path when PRESENT_DEC_EN is defined.
module tb_present_key_sched;

    logic        inClk = 1'b0;
    logic        inRstN;
    logic        inStart;
    logic [79:0] inKey;
    logic        dec_sel;
    logic [63:0] outRoundKey;
    logic        outValid;
    logic        inReady;
    logic [5:0]  outRoundIdx;
    logic        outBusy;
    logic        outDone;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_rk [1:32];
    localparam logic [63:0] SB_TBL = 64'hC56B90AD3EF84712;

    always #5 inClk = ~inClk;

    present_key_sched dut (
        .inClk       (inClk),
        .inRstN      (inRstN),
        .inStart     (inStart),
        .inKey       (inKey),
`ifdef PRESENT_DEC_EN
        .inDecrypt   (dec_sel),
`endif
        .outRoundKey (outRoundKey),
        .outValid    (outValid),
        .inReady     (inReady),
        .outRoundIdx (outRoundIdx),
        .outBusy     (outBusy),
        .outDone     (outDone)
    );

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [79:0] model_step(input logic [79:0] k, input logic [4:0] c);
        logic [159:0] d;
        logic [79:0]  r;
        d = {k, k} >> 19;
        r = d[79:0];
        r[79:76] = SB_TBL[(15 - int'(r[79:76])) * 4 +: 4];
        r[19:15] = r[19:15] ^ c;
        return r;
    endfunction

    task automatic gen_keys(input logic [79:0] k);
        logic [79:0] st;
        st = k;
        for (int i = 1; i <= 32; i++) begin
            exp_rk[i] = st[79:16];
            if (i < 32) st = model_step(st, 5'(i));
        end
    endtask

    task automatic reset_pulse();
        inRstN  = 1'b0;
        inStart = 1'b0;
        inReady = 1'b0;
        @(negedge inClk);
        inRstN = 1'b1;
    endtask

    task automatic do_start(input logic [79:0] k);
        inStart = 1'b1;
        inKey   = k;
        @(negedge inClk);
        inStart = 1'b0;
        inKey   = ~k;
    endtask

    // Runs from the first cycle after start until the done cycle, checking every transfer.
    task automatic run_seq(input bit rnd, input bit poke);
        int n = 0;
        int cyc = 0;
        int first = -1;
        int idx_e;
        bit held = 1'b0;
        logic [63:0] prev_k;
        logic [5:0]  prev_i;
        idx_e = dec_sel ? 32 : 1;
        while (n < 32 && cyc < 400) begin
            inReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            inStart = poke && (cyc == 5);
            if (poke && cyc == 5) inKey = '1;
            if (outValid) begin
                if (first < 0) begin
                    first = cyc;
                    check("first_valid_cyc", 80'(first), dec_sel ? 80'd31 : 80'd0);
                end
                if (held) begin
                    check("hold_key", outRoundKey, prev_k);
                    check("hold_idx", outRoundIdx, prev_i);
                end
                if (inReady) begin
                    check("rk", outRoundKey, exp_rk[idx_e]);
                    check("idx", outRoundIdx, 80'(idx_e));
                    n++;
                    idx_e = dec_sel ? idx_e - 1 : idx_e + 1;
                    held = 1'b0;
                end else begin
                    held   = 1'b1;
                    prev_k = outRoundKey;
                    prev_i = outRoundIdx;
                end
            end
            @(negedge inClk);
            cyc++;
        end
        inStart = 1'b0;
        inReady = 1'b0;
        if (n < 32) check("xfer_timeout", 80'(n), 80'd32);
        check("done_pulse", outDone, 1'b1);
        check("valid_after_last", outValid, 1'b0);
        check("busy_after_last", outBusy, 1'b0);
    endtask

    initial begin
        int guard;
        inRstN  = 1'b0;
        inStart = 1'b0;
        inReady = 1'b0;
        inKey   = '0;
        dec_sel = 1'b0;
        repeat (2) @(negedge inClk);
        check("rst_valid", outValid, 1'b0);
        check("rst_key", outRoundKey, 64'h0);
        check("rst_idx", outRoundIdx, 6'd0);
        check("rst_busy", outBusy, 1'b0);
        check("rst_done", outDone, 1'b0);
        inRstN = 1'b1;
        @(negedge inClk);

        // Hand-computed first keys for the all-zero user key.
        inReady = 1'b1;
        do_start(80'h0);
        check("k1_valid", outValid, 1'b1);
        check("k1_busy", outBusy, 1'b1);
        check("k1_key", outRoundKey, 64'h0000000000000000);
        check("k1_idx", outRoundIdx, 6'd1);
        @(negedge inClk);
        check("k2_key", outRoundKey, 64'hC000000000000000);
        check("k2_idx", outRoundIdx, 6'd2);
        @(negedge inClk);
        check("k3_key", outRoundKey, 64'h5000180000000001);
        check("k3_idx", outRoundIdx, 6'd3);
        reset_pulse();

        // Full encrypt run, ready always high.
        gen_keys(80'h0);
        inReady = 1'b1;
        do_start(80'h0);
        run_seq(1'b0, 1'b0);
        @(negedge inClk);
        check("done_clear", outDone, 1'b0);

        // Random back-pressure plus an ignored start; restart in the done cycle.
        do_start(80'h0);
        run_seq(1'b1, 1'b1);
        gen_keys(80'h0123456789ABCDEF4567);
        inStart = 1'b1;
        inKey   = 80'h0123456789ABCDEF4567;
        @(negedge inClk);
        inStart = 1'b0;
        inKey   = '0;
        check("restart_valid", outValid, 1'b1);
        check("restart_done_low", outDone, 1'b0);
        check("restart_k1", outRoundKey, 64'h0123456789ABCDEF);
        run_seq(1'b1, 1'b0);
        @(negedge inClk);

        // Reset while idx 10 is presented aborts without a done pulse.
        inReady = 1'b1;
        do_start(80'hFEDCBA9876543210AAAA);
        guard = 0;
        while (outRoundIdx != 6'd10 && guard < 100) begin
            @(negedge inClk);
            guard++;
        end
        check("reach_idx10", outRoundIdx, 6'd10);
        inRstN = 1'b0;
        @(negedge inClk);
        inRstN  = 1'b1;
        inReady = 1'b0;
        check("abort_valid", outValid, 1'b0);
        check("abort_key", outRoundKey, 64'h0);
        check("abort_idx", outRoundIdx, 6'd0);
        check("abort_busy", outBusy, 1'b0);
        check("abort_done", outDone, 1'b0);
        @(negedge inClk);
        check("abort_done_later", outDone, 1'b0);
        do_start(80'h13579BDF02468ACE1122);
        check("new_k1", outRoundKey, 64'h13579BDF02468ACE);
        check("new_idx", outRoundIdx, 6'd1);
        check("new_valid", outValid, 1'b1);
        reset_pulse();

`ifdef PRESENT_DEC_EN
        // Decrypt: precompute to K32, then serve in reverse.
        gen_keys(80'h0);
        dec_sel = 1'b1;
        do_start(80'h0);
        check("dec_busy_precomp", outBusy, 1'b1);
        check("dec_valid_precomp", outValid, 1'b0);
        run_seq(1'b1, 1'b0);
        dec_sel = 1'b0;
        @(negedge inClk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/present_key_sched.md
Name: present_key_sched

Overview:
- Sequential PRESENT-80 key scheduler.
- Loads an 80-bit user key and iterates the key-register update, counter values 1..31.
- Delivers the 32 round keys K1..K32 (register bits 79:16) to the round datapath over a valid/ready handshake, one key per transfer.
- Sits directly upstream of the round/addRoundKey stage and replaces open-loop stepping of the combinational key function.

Parameters:
- NROUNDS, 32, number of round keys delivered; fixed by PRESENT and not overridable in practice.

Ports:
- inClk  input  1  clock.
- inRstN  input  1  synchronous active-low reset, sampled on rising edge of inClk.
- inStart  input  1  start request; accepted only in IDLE.
- inKey  input  80  user key; sampled in the cycle inStart is accepted.
- inDecrypt  input  1  present only with PRESENT_DEC_EN; sampled with inStart.
- outRoundKey  output  64  current round key (key register bits 79:16).
- outValid  output  1  outRoundKey is valid.
- inReady  input  1  consumer accepts the key; a transfer occurs when outValid&&inReady.
- outRoundIdx  output  6  index of the presented key, 1..32.
- outBusy  output  1  high in any state other than IDLE.
- outDone  output  1  one-cycle pulse after the last transfer.

Behaviour:
- Reset values (inRstN=0 at an edge): state=IDLE; key register=0; round counter=0; outValid=0; outRoundKey=0; outRoundIdx=0; outBusy=0; outDone=0. Reset mid-operation aborts immediately; no done pulse.
- States: IDLE, PRECOMP (feature only), SERVE.
- IDLE to SERVE:
  - inStart=1 loads inKey into the key register and sets counter=1.
  - Next cycle: outValid=1, outRoundKey=inKey[79:16], outRoundIdx=1.
  - Start-to-first-valid latency is 1 cycle.
- SERVE:
  - outValid is held high and outRoundKey/outRoundIdx stay stable until a transfer occurs.
  - On transfer with idx<32, the key register takes its forward update with the current counter and idx increments. The next key is valid the following cycle, so back-to-back transfers run at 1 key/cycle.
  - Forward update:
    - rotate the key register left 61;
    - apply the S-box to bits 79:76;
    - XOR the 5-bit counter into bits 19:15.
  - The counter is 5 bits and never wraps, because the maximum counter used is 31.
  - On transfer with idx=32: go to IDLE, outValid=0, outDone=1 for exactly one cycle. The key register holds K32's full 80-bit state.
- inStart outside IDLE is ignored, including while outDone is high. inStart in the same cycle as outDone, with state already IDLE, is accepted.
- inReady while outValid=0 has no effect.
- inKey changes after the start is accepted have no effect.

Optional Feature:
- Macro: PRESENT_DEC_EN.
- With the macro:
  - inDecrypt exists. Start with inDecrypt=1 enters PRECOMP.
  - PRECOMP runs 31 forward updates, one per cycle, with outValid=0 and outBusy=1.
  - It then enters SERVE, presenting K32 (idx=32) 32 cycles after start.
  - Each transfer applies the inverse update in order: XOR counter into bits 19:15, inverse S-box on 79:76, rotate right 61. The counter decrements 31..1.
  - idx decrements; after K1 (idx=1) is transferred, outDone pulses.
  - Start with inDecrypt=0 behaves exactly as the base block.
- Without the macro: no inDecrypt port, no PRECOMP state, no inverse logic.

Decomposition:
- Package present_pkg holds:
  - the S-box and inverse S-box constant arrays;
  - key width 80 and round-key width 64;
  - NROUNDS=32;
  - the state enum (IDLE, PRECOMP, SERVE).
- One natural sub-module: present_key_step, combinational. It maps (key, counter, inverse flag) to the next key and is instantiated once in the block.

Test Plan:
- Key=0, start, inReady=1 constant → K1=0x0000000000000000 (idx1, 1 cycle after start), K2=0xC000000000000000, K3=0x5000180000000001. outDone pulses 1 cycle after the idx32 transfer; 32 transfers total.
- Key=0, inReady toggled pseudo-randomly → same 32-key sequence. outRoundKey/outRoundIdx are stable on every cycle with valid=1 and ready=0.
- inStart pulsed with key=all-ones during SERVE → ignored; sequence from the original key is unaffected.
- inRstN=0 at idx=10 → next cycle all outputs 0 and state IDLE. A new start then gives K1=new key[79:16].
- inStart asserted in the outDone cycle → accepted; K1 of the new key appears the next cycle.
- PRESENT_DEC_EN, key=0, inDecrypt=1 → first valid 32 cycles after start at idx=32 with the same K32 as the encrypt run. Keys come out in exact reverse order, ending idx=1 with K1=0, then outDone pulses.
